usb_desc_streamer: RTL and testbench

//  Control-IN data-stage source for standard descriptors. Latches a flat descriptor image
//  (device descriptor: 18 bytes, byte0 = bLength in bits [7:0]) on a GET_DESCRIPTOR start.

---
 rtl/usb_desc_streamer.sv | 237 +++++++++++++++++++++++
 tb/tb_usb_desc_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_desc_streamer.sv
`default_nettype none
// ============================================================================
// Module      : usb_desc_streamer
// Description : Control-IN data-stage source. Latches a descriptor image on
//               start and streams it as maxpkt-sized packets with ACK/retry
//               handling and a trailing zero-length packet when required.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_desc_streamer #(
    parameter int DESC_BYTES = 18
) (
    input  logic                    clk,
    input  logic                    rst0_async,
    input  logic [DESC_BYTES*8-1:0] desc_data,
    input  logic                    start,
    input  logic [15:0]             wlength,
    input  logic [7:0]              maxpkt,
    input  logic                    abort,
    input  logic                    pkt_req,
    input  logic                    pkt_ack,
    input  logic                    pkt_retry,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    tx_last,
    output logic                    tx_zlp,
    output logic                    busy,
    output logic                    done
);
    localparam int            PW         = $clog2(DESC_BYTES + 1);
    localparam logic [PW-1:0] C_DESC_LEN = PW'(DESC_BYTES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_IN  = 3'd1,
        S_SEND     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [DESC_BYTES*8-1:0] img_q, img_d;
    logic [PW-1:0]           total_q, total_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           base_q, base_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic [7:0]              mps_q, mps_d;
    logic                    zlp_need_q, zlp_need_d;
    logic                    zlp_sent_q, zlp_sent_d;
    logic                    zlp_sent_base_q, zlp_sent_base_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic                    tx_last_q, tx_last_d;
    logic                    tx_zlp_q, tx_zlp_d;
    logic                    done_q, done_d;

    logic [PW-1:0]           start_total;
    logic [7:0]              start_mps;
    logic                    start_zlp_need;
    logic                    load_beat;
    logic                    clear_beat;
    logic [PW-1:0]           beat_ptr;
    logic [PW-1:0]           beat_cnt;
    logic                    beat_zlp;
    logic [7:0]              beat_byte;

    always_comb begin
        state_d         = state_q;
        img_d           = img_q;
        total_d         = total_q;
        ptr_d           = ptr_q;
        base_d          = base_q;
        cnt_d           = cnt_q;
        mps_d           = mps_q;
        zlp_need_d      = zlp_need_q;
        zlp_sent_d      = zlp_sent_q;
        zlp_sent_base_d = zlp_sent_base_q;
        tx_data_d       = tx_data_q;
        tx_valid_d      = tx_valid_q;
        tx_last_d       = tx_last_q;
        tx_zlp_d        = tx_zlp_q;
        done_d          = (state_q == S_DONE);
        load_beat       = 1'b0;
        clear_beat      = 1'b0;
        beat_ptr        = ptr_q;
        beat_cnt        = cnt_q;
        beat_zlp        = 1'b0;
        beat_byte       = 8'd0;

        // total < wlength can only hold when total is clamped to DESC_BYTES
        start_total    = (wlength < 16'(DESC_BYTES)) ? wlength[PW-1:0] : C_DESC_LEN;
        start_mps      = (maxpkt == 8'd0) ? 8'd8 : maxpkt;
        start_zlp_need = (wlength > 16'(DESC_BYTES)) &&
                         ((16'(DESC_BYTES) % {8'd0, start_mps}) == 16'd0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    img_d           = desc_data;
                    total_d         = start_total;
                    mps_d           = start_mps;
                    zlp_need_d      = start_zlp_need;
                    ptr_d           = '0;
                    base_d          = '0;
                    cnt_d           = '0;
                    zlp_sent_d      = 1'b0;
                    zlp_sent_base_d = 1'b0;
                    state_d         = (wlength == 16'd0) ? S_DONE : S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                if (pkt_req) begin
                    state_d   = S_SEND;
                    cnt_d     = '0;
                    beat_ptr  = ptr_q;
                    beat_cnt  = '0;
                    load_beat = 1'b1;
                end
            end
            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    if (tx_zlp_q) begin
                        zlp_sent_d = 1'b1;
                        state_d    = S_WAIT_ACK;
                        clear_beat = 1'b1;
                    end else begin
                        ptr_d = ptr_q + PW'(1);
                        cnt_d = cnt_q + PW'(1);
                        if (tx_last_q) begin
                            state_d    = S_WAIT_ACK;
                            clear_beat = 1'b1;
                        end else begin
                            beat_ptr  = ptr_q + PW'(1);
                            beat_cnt  = cnt_q + PW'(1);
                            load_beat = 1'b1;
                        end
                    end
                end
            end
            S_WAIT_ACK: begin
                if (pkt_retry) begin
                    ptr_d      = base_q;
                    zlp_sent_d = zlp_sent_base_q;
                    state_d    = S_WAIT_IN;
                end else if (pkt_ack) begin
                    base_d          = ptr_q;
                    zlp_sent_base_d = zlp_sent_q;
                    if ((ptr_q == total_q) && (!zlp_need_q || zlp_sent_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_IN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < DESC_BYTES; i++) begin
            if (beat_ptr == PW'(i)) begin
                beat_byte = img_q[i*8 +: 8];
            end
        end

        // A beat launched with ptr at the end of the data is the ZLP
        if (load_beat) begin
            beat_zlp   = (beat_ptr == total_q);
            tx_valid_d = 1'b1;
            tx_zlp_d   = beat_zlp;
            tx_data_d  = beat_zlp ? 8'd0 : beat_byte;
            tx_last_d  = beat_zlp ||
                         ((9'(beat_cnt) + 9'd1) == {1'b0, mps_q}) ||
                         ((9'(beat_ptr) + 9'd1) == 9'(total_q));
        end

        if (clear_beat || abort) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'd0;
            tx_last_d  = 1'b0;
            tx_zlp_d   = 1'b0;
        end

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst0_async) begin
        if (!rst0_async) begin
            state_q         <= S_IDLE;
            img_q           <= '0;
            total_q         <= '0;
            ptr_q           <= '0;
            base_q          <= '0;
            cnt_q           <= '0;
            mps_q           <= 8'd0;
            zlp_need_q      <= 1'b0;
            zlp_sent_q      <= 1'b0;
            zlp_sent_base_q <= 1'b0;
            tx_data_q       <= 8'd0;
            tx_valid_q      <= 1'b0;
            tx_last_q       <= 1'b0;
            tx_zlp_q        <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            img_q           <= img_d;
            total_q         <= total_d;
            ptr_q           <= ptr_d;
            base_q          <= base_d;
            cnt_q           <= cnt_d;
            mps_q           <= mps_d;
            zlp_need_q      <= zlp_need_d;
            zlp_sent_q      <= zlp_sent_d;
            zlp_sent_base_q <= zlp_sent_base_d;
            tx_data_q       <= tx_data_d;
            tx_valid_q      <= tx_valid_d;
            tx_last_q       <= tx_last_d;
            tx_zlp_q        <= tx_zlp_d;
            done_q          <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign tx_last  = tx_last_q;
    assign tx_zlp   = tx_zlp_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_usb_desc_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_usb_desc_streamer
// Description : Self-checking bench for usb_desc_streamer (18- and 16-byte
//               instances) against a packet-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_desc_streamer;
    localparam int NB = 18;

    logic           clk        = 1'b0;
    logic           rst0_async = 1'b0;
    logic [NB*8-1:0] desc_a    = '0;
    logic [16*8-1:0] desc_b    = '0;
    logic           start_a = 1'b0, start_b = 1'b0;
    logic [15:0]    wlength = 16'd0;
    logic [7:0]     maxpkt  = 8'd0;
    logic           abort = 1'b0, pkt_req = 1'b0, pkt_ack = 1'b0, pkt_retry = 1'b0;
    logic           tx_ready = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, a_zlp, a_busy, a_done;
    logic       b_valid, b_last, b_zlp, b_busy, b_done;

    logic       sel = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last, tx_zlp, busy, done;
    assign tx_data  = sel ? b_data  : a_data;
    assign tx_valid = sel ? b_valid : a_valid;
    assign tx_last  = sel ? b_last  : a_last;
    assign tx_zlp   = sel ? b_zlp   : a_zlp;
    assign busy     = sel ? b_busy  : a_busy;
    assign done     = sel ? b_done  : a_done;

    usb_desc_streamer #(.DESC_BYTES(NB)) dut_a (
        .clk(clk), .rst0_async(rst0_async), .desc_data(desc_a), .start(start_a),
        .wlength(wlength), .maxpkt(maxpkt), .abort(abort), .pkt_req(pkt_req),
        .pkt_ack(pkt_ack), .pkt_retry(pkt_retry), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(tx_ready), .tx_last(a_last), .tx_zlp(a_zlp), .busy(a_busy), .done(a_done)
    );

    usb_desc_streamer #(.DESC_BYTES(16)) dut_b (
        .clk(clk), .rst0_async(rst0_async), .desc_data(desc_b), .start(start_b),
        .wlength(wlength), .maxpkt(maxpkt), .abort(abort), .pkt_req(pkt_req),
        .pkt_ack(pkt_ack), .pkt_retry(pkt_retry), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(tx_ready), .tx_last(b_last), .tx_zlp(b_zlp), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] img [NB];
    int         exp_len [$];
    bit         exp_zlp [$];
    logic [7:0] got_q [$];
    bit         got_zlp;

    typedef struct {
        bit sel;
        int wl;
        int mp;
        int retry;
        bit stall;
        int npk;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: chop min(wl, nb) bytes into packets of mp (0 -> 8), ZLP when short and aligned
    task automatic build_model(input int nb, input int wl, input int mp);
        int total, m, off;
        exp_len = {};
        exp_zlp = {};
        total = (wl < nb) ? wl : nb;
        m     = (mp == 0) ? 8 : mp;
        off   = 0;
        while (off < total) begin
            int len;
            len = ((total - off) < m) ? (total - off) : m;
            exp_len.push_back(len);
            exp_zlp.push_back(1'b0);
            off += len;
        end
        if ((total < wl) && ((total % m) == 0)) begin
            exp_len.push_back(0);
            exp_zlp.push_back(1'b1);
        end
    endtask

    task automatic do_start(input bit s, input int wl, input int mp);
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        sel     = s;
        wlength = 16'(wl);
        maxpkt  = 8'(mp);
        for (int i = 0; i < NB; i++) desc_a[i*8 +: 8] = img[i];
        for (int i = 0; i < 16; i++) desc_b[i*8 +: 8] = img[i];
        if (s) start_b = 1'b1;
        else   start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        desc_a  = ~desc_a;
        desc_b  = ~desc_b;
        wlength = 16'($urandom);
        maxpkt  = 8'($urandom);
    endtask

    task automatic recv(input bit stall, output bit ok);
        bit         hold = 1'b0;
        logic [7:0] pd = 8'd0;
        logic       pl = 1'b0, pz = 1'b0;
        got_q   = {};
        got_zlp = 1'b0;
        ok      = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (hold) begin
                chk("hold valid", 32'(tx_valid), 32'd1);
                chk("hold data", 32'(tx_data), 32'(pd));
                chk("hold last", 32'(tx_last), 32'(pl));
                chk("hold zlp", 32'(tx_zlp), 32'(pz));
            end
            if (tx_valid) begin
                tx_ready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
                hold = !tx_ready;
                pd   = tx_data;
                pl   = tx_last;
                pz   = tx_zlp;
                if (tx_ready) begin
                    if (tx_zlp) begin
                        got_zlp = 1'b1;
                        chk("zlp data", 32'(tx_data), 32'd0);
                        chk("zlp last", 32'(tx_last), 32'd1);
                    end else begin
                        got_q.push_back(tx_data);
                    end
                    if (tx_last) ok = 1'b1;
                end
            end else begin
                hold     = 1'b0;
                tx_ready = stall ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            @(negedge clk);
            if (ok) break;
        end
        tx_ready = 1'b0;
        if (!ok) chk("packet end timeout", 32'd0, 32'd1);
    endtask

    task automatic do_packets(input int retry, input bit stall, output int seen);
        int off;
        bit ok;
        off  = 0;
        seen = 0;
        for (int p = 0; p < exp_len.size(); p++) begin
            int tries;
            tries = (p + 1 == retry) ? 2 : 1;
            for (int t = 0; t < tries; t++) begin
                pkt_req = 1'b1;
                @(negedge clk);
                pkt_req = 1'b0;
                chk("first-beat latency", 32'(tx_valid), 32'd1);
                recv(stall, ok);
                if (ok && (t + 1 == tries)) seen++;
                chk("valid after last beat", 32'(tx_valid), 32'd0);
                chk("busy in packet", 32'(busy), 32'd1);
                chk($sformatf("pkt %0d length", p), 32'(got_q.size()), 32'(exp_len[p]));
                chk($sformatf("pkt %0d zlp", p), 32'(got_zlp), 32'(exp_zlp[p]));
                for (int i = 0; i < got_q.size() && i < exp_len[p]; i++)
                    chk($sformatf("byte %0d", off + i), 32'(got_q[i]), 32'(img[off + i]));
                if (t + 1 < tries) pkt_retry = 1'b1;
                else               pkt_ack   = 1'b1;
                @(negedge clk);
                pkt_retry = 1'b0;
                pkt_ack   = 1'b0;
                chk("no early done", 32'(done), 32'd0);
            end
            off += exp_len[p];
        end
        @(negedge clk);
        chk("done pulse", 32'(done), 32'd1);
        chk("idle after done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done single cycle", 32'(done), 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        bit ok;

        img = '{8'h12, 8'h01, 8'h10, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h08, 8'h34,
                8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};

        //            sel wl   mp retry stall npk
        vt[0] = '{1'b0,  64,  8, 0, 1'b0, 3};
        vt[1] = '{1'b0,   5, 64, 0, 1'b0, 1};
        vt[2] = '{1'b1, 255,  8, 0, 1'b0, 3};
        vt[3] = '{1'b0,  64,  8, 2, 1'b0, 3};
        vt[4] = '{1'b0,  64,  8, 0, 1'b1, 3};
        vt[5] = '{1'b0,  18,  0, 0, 1'b1, 3};
        vt[6] = '{1'b0, 100,  9, 3, 1'b1, 3};
        vt[7] = '{1'b0,  17,  1, 0, 1'b1, 17};
        vt[8] = '{1'b1,  16,  4, 0, 1'b0, 4};
        vt[9] = '{1'b0,  19,  6, 4, 1'b1, 4};

        repeat (3) @(negedge clk);
        chk("reset a valid", 32'(a_valid), 32'd0);
        chk("reset a busy", 32'(a_busy), 32'd0);
        chk("reset a done", 32'(a_done), 32'd0);
        chk("reset a data", 32'({a_data, a_last, a_zlp}), 32'd0);
        chk("reset b outputs", 32'({b_data, b_valid, b_last, b_zlp, b_busy, b_done}), 32'd0);
        rst0_async = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            build_model(vt[v].sel ? 16 : NB, vt[v].wl, vt[v].mp);
            do_start(vt[v].sel, vt[v].wl, vt[v].mp);
            do_packets(vt[v].retry, vt[v].stall, seen);
            chk($sformatf("vec %0d packets", v), 32'(seen), 32'(vt[v].npk));
        end

        // wlength = 0: done two cycles after start, nothing transmitted
        build_model(NB, 0, 8);
        do_start(1'b0, 0, 8);
        chk("wl0 busy", 32'(busy), 32'd1);
        chk("wl0 no valid", 32'(tx_valid), 32'd0);
        chk("wl0 done not yet", 32'(done), 32'd0);
        @(negedge clk);
        chk("wl0 done", 32'(done), 32'd1);
        chk("wl0 no valid 2", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("wl0 done once", 32'(done), 32'd0);

        // Abort in the middle of packet 2
        build_model(NB, 64, 8);
        do_start(1'b0, 64, 8);
        pkt_req = 1'b1;
        @(negedge clk);
        pkt_req = 1'b0;
        recv(1'b0, ok);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
        pkt_req = 1'b1;
        @(negedge clk);
        pkt_req  = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort pre valid", 32'(tx_valid), 32'd1);
        chk("abort pre data", 32'(tx_data), 32'(img[11]));
        tx_ready = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort valid", 32'(tx_valid), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort no done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // Start while busy is ignored
        build_model(NB, 5, 64);
        do_start(1'b0, 5, 64);
        chk("busy after start", 32'(busy), 32'd1);
        start_a = 1'b1;
        wlength = 16'd64;
        maxpkt  = 8'd8;
        @(negedge clk);
        start_a = 1'b0;
        do_packets(0, 1'b1, seen);
        chk("start-while-busy packets", 32'(seen), 32'd1);

        // Randomized transfers against the model
        for (int r = 0; r < 16; r++) begin
            bit s;
            int nb, wl, mp, retry;
            s  = 1'($urandom_range(1, 0));
            nb = s ? 16 : NB;
            for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
            case ($urandom_range(3, 0))
                0:       wl = $urandom_range(nb + 2, 0);
                1:       wl = $urandom_range(300, nb);
                2:       wl = 64;
                default: wl = 255;
            endcase
            case ($urandom_range(3, 0))
                0:       mp = 0;
                1:       mp = $urandom_range(20, 1);
                2:       mp = 8;
                default: mp = 64;
            endcase
            build_model(nb, wl, mp);
            retry = $urandom_range(exp_len.size(), 0);
            do_start(s, wl, mp);
            do_packets(retry, 1'b1, seen);
            chk($sformatf("rand %0d packets", r), 32'(seen), 32'(exp_len.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
